// File: rtl/complex_res_accumulator_pkg.sv
// Shared types and helpers for the complex result accumulator, plus {re,im} field slicing
// common with the multiplier result format.
`ifndef COMPLEX_RES_ACCUMULATOR_PKG_SV
`define COMPLEX_RES_ACCUMULATOR_PKG_SV

// d is a 4*w-bit word packed as {re, im}, each field 2*w bits wide.
`define CPLX_RE(d, w) d[4*(w)-1:2*(w)]
`define CPLX_IM(d, w) d[2*(w)-1:0]

package complex_res_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/complex_res_accumulator_cplx_acc_lane.sv
// One signed accumulator lane: sign-extends each sample, adds it into a running sum,
// and captures the final sum into an output register that holds until the next capture.
module cplx_acc_lane #(
    parameter int ACC_W = 18,
    parameter int IN_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sw_rst,
    input  logic             i_add,
    input  logic             i_cap,
    input  logic             i_clr,
    input  logic [IN_W-1:0]  i_dat,
    output logic [ACC_W-1:0] o_sum
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out;
    logic [ACC_W-1:0] w_sum;

    // Sum wraps modulo 2^ACC_W; the guard bits keep a full frame in range.
    assign w_sum = r_acc + ACC_W'($signed(i_dat));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (sw_rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_add) begin
                r_acc <= w_sum;
            end
            if (i_cap) begin
                r_out <= w_sum;
            end
        end
    end

    assign o_sum = r_out;
endmodule

// File: rtl/complex_res_accumulator.sv
// Complex MAC back end: sums up to ACC_LEN {re,im} samples per frame and presents the sum,
// one cycle after the last sample, on a registered valid/ready output.
module complex_res_accumulator
    import complex_res_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_LEN    = 4,
    parameter int GUARD      = 2,
    localparam int ACC_W     = 2*DATA_WIDTH + GUARD,
    localparam int CNT_W     = clog2(ACC_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    in_val,
    output logic                    in_ready,
    input  logic [4*DATA_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_val,
    input  logic                    out_ready,
    output logic [2*ACC_W-1:0]      out_data,
    output logic [CNT_W-1:0]        out_cnt
);
    localparam int IN_W = 2*DATA_WIDTH;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_frame_end;
    logic [ACC_W-1:0] w_sum_re;
    logic [ACC_W-1:0] w_sum_im;

    // Handshake decode uses state only, so neither ready nor valid depends on the far side.
    assign in_ready    = (r_state == ACCUM);
    assign out_val     = (r_state == DONE);
    assign w_in_xfer   = in_val & in_ready;
    assign w_out_xfer  = out_val & out_ready;
    assign w_frame_end = w_in_xfer & (in_last | (r_cnt == CNT_W'(ACC_LEN - 1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_frame_end) w_state_nxt = DONE;
            DONE:    if (w_out_xfer)  w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ACCUM;
            r_cnt     <= '0;
            r_out_cnt <= '0;
        end else if (sw_rst) begin
            r_state   <= ACCUM;
            r_cnt     <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_out_xfer) begin
                r_cnt <= '0;
            end else if (w_in_xfer) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_frame_end) begin
                r_out_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    cplx_acc_lane #(.ACC_W(ACC_W), .IN_W(IN_W)) u_lane_re (
        .clk    (clk),
        .rstn   (rstn),
        .sw_rst (sw_rst),
        .i_add  (w_in_xfer),
        .i_cap  (w_frame_end),
        .i_clr  (w_out_xfer),
        .i_dat  (`CPLX_RE(in_data, DATA_WIDTH)),
        .o_sum  (w_sum_re)
    );

    cplx_acc_lane #(.ACC_W(ACC_W), .IN_W(IN_W)) u_lane_im (
        .clk    (clk),
        .rstn   (rstn),
        .sw_rst (sw_rst),
        .i_add  (w_in_xfer),
        .i_cap  (w_frame_end),
        .i_clr  (w_out_xfer),
        .i_dat  (`CPLX_IM(in_data, DATA_WIDTH)),
        .o_sum  (w_sum_im)
    );

    assign out_data = {w_sum_re, w_sum_im};
    assign out_cnt  = r_out_cnt;
endmodule

// File: tb/tb_complex_res_accumulator.sv
// Bench for complex_res_accumulator (DATA_WIDTH=8, ACC_LEN=4, GUARD=2): a bench-side model
// pushes expected frame sums to a queue as samples are driven; results are popped on output.
module tb_complex_res_accumulator;
    typedef struct packed {
        logic [17:0] re;
        logic [17:0] im;
        logic [2:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sw_rst;
    logic        in_val;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_val;
    logic        out_ready;
    logic [35:0] out_data;
    logic [2:0]  out_cnt;

    exp_t        sb[$];
    logic [17:0] m_re;
    logic [17:0] m_im;
    int          m_cnt;
    int          n_cmp;
    int          n_bad;

    complex_res_accumulator #(.DATA_WIDTH(8), .ACC_LEN(4), .GUARD(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .in_val    (in_val),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_val   (out_val),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_re  = '0;
        m_im  = '0;
        m_cnt = 0;
    endtask

    // Drives one sample until it transfers, then updates the model.
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
        int   n;
        exp_t e;
        n       = 0;
        in_val  = 1'b1;
        in_data = {re, im};
        in_last = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk); #1;
            m_re  = m_re + {{2{re[15]}}, re};
            m_im  = m_im + {{2{im[15]}}, im};
            m_cnt = m_cnt + 1;
            if (last || m_cnt == 4) begin
                e.re  = m_re;
                e.im  = m_im;
                e.cnt = 3'(m_cnt);
                sb.push_back(e);
                model_clear();
            end
        end
        in_val  = 1'b0;
        in_last = 1'b0;
        in_data = '0;
    endtask

    // Waits for out_val, samples the result and completes the output handshake.
    task automatic get_result(output logic [35:0] d, output logic [2:0] c, output bit ok);
        int n;
        n = 0;
        while (out_val !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok        = (out_val === 1'b1);
        d         = out_data;
        c         = out_cnt;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sw_rst = 1'b0; in_val = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b0;
        model_clear();
        #3;
        n_cmp += 4;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (out_val !== 1'b0) begin n_bad++; $display("FAIL reset_out_val got=%b want=0", out_val); end
        if (out_data !== 36'd0) begin n_bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        if (out_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_out_cnt got=%0d want=0", out_cnt); end
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        logic [35:0] d; logic [2:0] c; bit ok; exp_t e;
        for (int i = 1; i <= 4; i++) send(16'(i), 16'hFFFF, 1'b0);
        n_cmp++;
        if (out_val !== 1'b1) begin n_bad++; $display("FAIL full_latency out_val=%b want=1", out_val); end
        get_result(d, c, ok);
        e = sb.pop_front();
        n_cmp += 5;
        if (!ok || d !== {e.re, e.im}) begin n_bad++; $display("FAIL full_data got=%h want=%h", d, {e.re, e.im}); end
        if (c !== e.cnt) begin n_bad++; $display("FAIL full_cnt got=%0d want=%0d", c, e.cnt); end
        if (d[35:18] !== 18'd10) begin n_bad++; $display("FAIL full_re got=%h want=%h", d[35:18], 18'd10); end
        if (d[17:0] !== 18'h3FFFC) begin n_bad++; $display("FAIL full_im got=%h want=3fffc", d[17:0]); end
        if (in_ready !== 1'b1 || out_val !== 1'b0) begin
            n_bad++; $display("FAIL full_return in_ready=%b out_val=%b want 1/0", in_ready, out_val);
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] d; logic [2:0] c; bit ok; exp_t e;
        for (int i = 0; i < 4; i++) send(16'd3, 16'd2, 1'b0);
        e         = sb[0];
        in_val    = 1'b1;
        in_data   = 32'h0100_0100;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_data !== {e.re, e.im} || in_ready !== 1'b0 || out_val !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d data=%h in_ready=%b out_val=%b want data=%h 0/1",
                         i, out_data, in_ready, out_val, {e.re, e.im});
            end
        end
        in_val  = 1'b0;
        in_data = '0;
        get_result(d, c, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || d !== {e.re, e.im} || c !== e.cnt) begin
            n_bad++; $display("FAIL bp_result got=%h/%0d want=%h/%0d", d, c, {e.re, e.im}, e.cnt);
        end
        for (int i = 0; i < 4; i++) send(16'd1, 16'd1, 1'b0);
        get_result(d, c, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || d !== {e.re, e.im} || c !== e.cnt) begin
            n_bad++; $display("FAIL bp_next_frame got=%h/%0d want=%h/%0d", d, c, {e.re, e.im}, e.cnt);
        end
    endtask

    task automatic test_last();
        logic [35:0] d; logic [2:0] c; bit ok; exp_t e;
        send(16'd5, 16'd0, 1'b0);
        send(16'd7, 16'd0, 1'b1);
        n_cmp++;
        if (out_val !== 1'b1) begin n_bad++; $display("FAIL last_latency out_val=%b want=1", out_val); end
        get_result(d, c, ok);
        e = sb.pop_front();
        n_cmp += 2;
        if (!ok || d !== {e.re, e.im}) begin n_bad++; $display("FAIL last_data got=%h want=%h", d, {e.re, e.im}); end
        if (c !== e.cnt) begin n_bad++; $display("FAIL last_cnt got=%0d want=%0d", c, e.cnt); end
    endtask

    task automatic test_extremes();
        logic [35:0] d; logic [2:0] c; bit ok; exp_t e;
        for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h8000, 1'b0);
        get_result(d, c, ok);
        e = sb.pop_front();
        n_cmp += 3;
        if (!ok || d !== {e.re, e.im}) begin n_bad++; $display("FAIL ext_data got=%h want=%h", d, {e.re, e.im}); end
        if (d[35:18] !== 18'h1FFFC) begin n_bad++; $display("FAIL ext_re got=%h want=1fffc", d[35:18]); end
        if (d[17:0] !== 18'h20000) begin n_bad++; $display("FAIL ext_im got=%h want=20000", d[17:0]); end
    endtask

    task automatic test_sw_rst();
        logic [35:0] d; logic [2:0] c; bit ok; exp_t e;
        send(16'd9, 16'd0, 1'b0);
        send(16'd9, 16'd0, 1'b0);
        sw_rst = 1'b1;
        @(posedge clk); #1;
        sw_rst = 1'b0;
        model_clear();
        n_cmp++;
        if (in_ready !== 1'b1 || out_val !== 1'b0) begin
            n_bad++; $display("FAIL swrst_state in_ready=%b out_val=%b want 1/0", in_ready, out_val);
        end
        for (int i = 0; i < 4; i++) send(16'd1, 16'd0, 1'b0);
        get_result(d, c, ok);
        e = sb.pop_front();
        n_cmp += 2;
        if (!ok || d !== {e.re, e.im}) begin n_bad++; $display("FAIL swrst_data got=%h want=%h", d, {e.re, e.im}); end
        if (c !== e.cnt) begin n_bad++; $display("FAIL swrst_cnt got=%0d want=%0d", c, e.cnt); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) send(16'd2, 16'd3, 1'b0);
        n_cmp++;
        if (out_val !== 1'b1) begin n_bad++; $display("FAIL arst_pre out_val=%b want=1", out_val); end
        sb.delete();
        rstn = 1'b0;
        #1;
        n_cmp += 4;
        if (out_val !== 1'b0) begin n_bad++; $display("FAIL arst_out_val got=%b want=0", out_val); end
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready got=%b want=1", in_ready); end
        if (out_data !== 36'd0) begin n_bad++; $display("FAIL arst_out_data got=%h want=0", out_data); end
        if (out_cnt !== 3'd0) begin n_bad++; $display("FAIL arst_out_cnt got=%0d want=0", out_cnt); end
        model_clear();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_last();
        test_extremes();
        test_sw_rst();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
